// File: rtl/kw11l_pkg.sv
// kw11l_pkg: shared constants and types for the KW11-L line-clock controller.
//   LCS_ADDR    bus address of the line clock status register (177546)
//   LCM_BIT/IE_BIT  bit positions of monitor and interrupt-enable in LCS
//   VECTOR_DEF  default interrupt vector (100 octal)
//   irq_state_e interrupt handshake FSM encoding
//   lcs_word()  assembles the 16-bit LCS read value
package kw11l_pkg;

  localparam logic [15:0] LCS_ADDR   = 16'o177546;
  localparam int          LCM_BIT    = 7;
  localparam int          IE_BIT     = 6;
  localparam logic [7:0]  VECTOR_DEF = 8'o100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK  = 2'd2
  } irq_state_e;

  function automatic logic [15:0] lcs_word(input logic lcm, input logic ie);
    logic [15:0] w;
    w          = '0;
    w[LCM_BIT] = lcm;
    w[IE_BIT]  = ie;
    return w;
  endfunction

endpackage

// File: rtl/kw11l_tick.sv
// kw11l_tick: turns the 50 Hz irq50 square wave into a one-cycle tick pulse.
// Build option: KW11L_SYNC_EN inserts a 2-flop synchronizer ahead of the
// edge detector (adds 2 cycles of latency) for asynchronous irq50 sources.
//   clk, rstin  clock, async active-low reset
//   clr         synchronous clear (DC power fail), same effect as reset
//   irq50       50 Hz line clock input
//   tick        registered one-cycle pulse per irq50 rising edge
module kw11l_tick (
  input  logic clk,
  input  logic rstin,
  input  logic clr,
  input  logic irq50,
  output logic tick
);

  logic line;
  logic prev;

`ifdef KW11L_SYNC_EN
  logic [1:0] sync;
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin)   sync <= '0;
    else if (clr) sync <= '0;
    else          sync <= {sync[0], irq50};
  end
  assign line = sync[1];
`else
  assign line = irq50;
`endif

  // History resets to 0, so a line already high at reset exit is a tick.
  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      prev <= 1'b0;
      tick <= 1'b0;
    end else if (clr) begin
      prev <= 1'b0;
      tick <= 1'b0;
    end else begin
      prev <= line;
      tick <= line & ~prev;
    end
  end

endmodule

// File: rtl/kw11l.sv
// kw11l: KW11-L line-clock interrupt controller with Wishbone LCS access.
// Build option: KW11L_SYNC_EN (see kw11l_tick) synchronizes irq50.
//   clk, rstin        50 MHz clock, async active-low reset
//   dclo              DC power fail: synchronous clear of all state
//   aclo              AC power fail: ticks ignored
//   irq50             50 Hz line clock
//   wb_*              Wishbone slave port for the LCS register
//   irq, iack, ivec   interrupt request/acknowledge/vector to the arbiter
module kw11l
  import kw11l_pkg::*;
#(
  parameter logic [7:0] VECTOR = VECTOR_DEF
) (
  input  logic        clk,
  input  logic        rstin,
  input  logic        dclo,
  input  logic        aclo,
  input  logic        irq50,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq,
  input  logic        iack,
  output logic [8:0]  ivec
);

  logic       tick_raw, tick;
  logic       lcm, ie, pending;
  logic       bus_sel, wr_en, pend_clr;
  irq_state_e state;

  // Only the low byte carries LCS bits.
  logic unused_bits;
  assign unused_bits = ^{wb_sel_i[1], wb_dat_i[15:8], wb_dat_i[5:0]};

  kw11l_tick u_tick (
    .clk   (clk),
    .rstin (rstin),
    .clr   (dclo),
    .irq50 (irq50),
    .tick  (tick_raw)
  );

  assign tick    = tick_raw & ~aclo;
  assign ivec    = {1'b0, VECTOR};
  assign bus_sel = wb_cyc_i & wb_stb_i;
  // Write lands only on the cycle that raises ack, not on every held cycle.
  assign wr_en    = bus_sel & wb_we_i & wb_sel_i[0] & ~wb_ack_o;
  assign pend_clr = (state == ST_REQ) & iack;

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      lcm      <= 1'b0;
      ie       <= 1'b0;
      pending  <= 1'b0;
    end else if (dclo) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      lcm      <= 1'b0;
      ie       <= 1'b0;
      pending  <= 1'b0;
    end else begin
      wb_ack_o <= bus_sel;
      wb_dat_o <= bus_sel ? lcs_word(lcm, ie) : '0;
      // A tick beats a same-cycle write that clears LCM.
      if (tick)                           lcm <= 1'b1;
      else if (wr_en && !wb_dat_i[LCM_BIT]) lcm <= 1'b0;
      if (wr_en) ie <= wb_dat_i[IE_BIT];
      // Ticks merge into one pending flag; a tick coinciding with iack
      // re-arms it. Pending never survives IE=0.
      pending <= ie & ((pending & ~pend_clr) | tick);
    end
  end

  always_ff @(posedge clk or negedge rstin) begin
    if (!rstin) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
    end else if (dclo) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (pending && ie) begin
          state <= ST_REQ;
          irq   <= 1'b1;
        end
        ST_REQ: if (iack) begin
          state <= ST_ACK;
          irq   <= 1'b0;
        end else if (!ie) begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
        ST_ACK: begin
          irq <= 1'b0;
          if (!iack) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_kw11l.sv
// tb_kw11l: directed self-checking bench for kw11l. Inputs change 1 ns after
// the rising edge; outputs are sampled at the same point, i.e. after the
// edge that consumed the previous input set.
module tb_kw11l;

`ifdef KW11L_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic        clk = 1'b0;
  logic        rstin, dclo, aclo, irq50;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [1:0]  wb_sel_i;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, irq, iack;
  logic [8:0]  ivec;

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  kw11l dut (
    .clk      (clk),
    .rstin    (rstin),
    .dclo     (dclo),
    .aclo     (aclo),
    .irq50    (irq50),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq      (irq),
    .iack     (iack),
    .ivec     (ivec)
  );

  task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %o expected %o", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_write(input string tag, input logic [15:0] d, input logic [1:0] s);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = s; wb_dat_i = d;
    step();
    chk({tag, "_ack"}, 16'(wb_ack_o), 16'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
  endtask

  // Read with strobe held two cycles: ack must stay up, then drop.
  task automatic wb_read(input string tag, input logic [15:0] exp);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 2'b01;
    step();
    chk({tag, "_ack"}, 16'(wb_ack_o), 16'd1);
    chk(tag, wb_dat_o, exp);
    step();
    chk({tag, "_ackhold"}, 16'(wb_ack_o), 16'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    step();
    chk({tag, "_ackdrop"}, 16'(wb_ack_o), 16'd0);
  endtask

  // Full irq50 pulse with enough low time for the edge detector to rearm.
  task automatic pulse50();
    irq50 = 1'b1;
    step(2 + SYNC);
    irq50 = 1'b0;
    step(2 + SYNC);
  endtask

  initial begin
    rstin = 1'b0; dclo = 1'b0; aclo = 1'b0; irq50 = 1'b0; iack = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_sel_i = 2'b00; wb_dat_i = '0;
    step(3);
    rstin = 1'b1;
    step();

    // Reset state
    chk("rst_ack", 16'(wb_ack_o), 16'd0);
    chk("rst_dat", wb_dat_o, 16'd0);
    chk("rst_irq", 16'(irq), 16'd0);
    chk("ivec", 16'(ivec), 16'o100);
    wb_read("rst_lcs", 16'o000000);

    // IE=0: tick sets LCM only
    irq50 = 1'b1;
    step(3 + SYNC);
    chk("ie0_irq", 16'(irq), 16'd0);
    irq50 = 1'b0;
    step(2 + SYNC);
    wb_read("ie0_lcs", 16'o000200);

    // IE=1: irq exactly two cycles after the sampled edge
    wb_write("wr_ie", 16'o000100, 2'b01);
    wb_read("ie1_lcs", 16'o000100);
    irq50 = 1'b1;
    step(2 + SYNC);
    chk("lat_early", 16'(irq), 16'd0);
    step();
    chk("lat_irq", 16'(irq), 16'd1);
    irq50 = 1'b0;
    iack = 1'b1;
    step();
    chk("iack_drop", 16'(irq), 16'd0);
    iack = 1'b0;
    step(2 + SYNC);
    chk("post_ack_irq", 16'(irq), 16'd0);
    chk("ivec_ack", 16'(ivec), 16'o100);

    // LCM write semantics (LCM is 1 from the last tick)
    wb_write("wr_300", 16'o000300, 2'b01);
    wb_read("lcm_keep", 16'o000300);
    wb_write("wr_100", 16'o000100, 2'b01);
    wb_read("lcm_clr", 16'o000100);
    wb_write("wr_nosel", 16'o000000, 2'b10);
    wb_read("nosel_lcs", 16'o000100);

    // Tick coinciding with iack re-raises irq after ACK->IDLE
    pulse50();
    chk("t5_irq1", 16'(irq), 16'd1);
    irq50 = 1'b1;
    step(1 + SYNC);
    iack = 1'b1;
    step();
    chk("t5_iack", 16'(irq), 16'd0);
    irq50 = 1'b0;
    step();
    chk("t5_ackwait", 16'(irq), 16'd0);
    iack = 1'b0;
    step();
    chk("t5_idle", 16'(irq), 16'd0);
    step();
    chk("t5_irq2", 16'(irq), 16'd1);
    iack = 1'b1;
    step();
    iack = 1'b0;
    step(2);
    chk("t5_done", 16'(irq), 16'd0);

    // Tick in same cycle as a write of 0: tick wins
    wb_write("wr_0", 16'o000000, 2'b01);
    wb_read("t4_clr", 16'o000000);
    pulse50();
    wb_read("t4_set", 16'o000200);
    wb_write("wr_0b", 16'o000000, 2'b01);
    wb_read("t4_clr2", 16'o000000);
    irq50 = 1'b1;
    step(1 + SYNC);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_sel_i = 2'b01; wb_dat_i = '0;
    step();
    chk("t4_wack", 16'(wb_ack_o), 16'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    irq50 = 1'b0;
    step(2 + SYNC);
    wb_read("t4_win", 16'o000200);
    chk("t4_irq", 16'(irq), 16'd0);

    // aclo: ticks ignored
    wb_write("wr_ie2", 16'o000100, 2'b01);
    aclo = 1'b1;
    for (int i = 0; i < 3; i++) begin
      irq50 = 1'b1;
      step(3 + SYNC);
      chk("aclo_irq", 16'(irq), 16'd0);
      irq50 = 1'b0;
      step(2 + SYNC);
    end
    aclo = 1'b0;
    step();
    wb_read("aclo_lcs", 16'o000100);

    // dclo while requesting
    irq50 = 1'b1;
    step(3 + SYNC);
    chk("dclo_pre", 16'(irq), 16'd1);
    irq50 = 1'b0;
    step(2 + SYNC);
    dclo = 1'b1;
    step();
    dclo = 1'b0;
    chk("dclo_irq", 16'(irq), 16'd0);
    step(2);
    chk("dclo_stay", 16'(irq), 16'd0);
    wb_read("dclo_lcs", 16'o000000);

    // async reset while requesting
    wb_write("wr_ie3", 16'o000100, 2'b01);
    pulse50();
    chk("rst_pre", 16'(irq), 16'd1);
    rstin = 1'b0;
    #2;
    chk("rst_async", 16'(irq), 16'd0);
    step();
    rstin = 1'b1;
    step(2);
    chk("rst_after", 16'(irq), 16'd0);
    wb_read("rst_lcs2", 16'o000000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kw11l.md
# kw11l

Line-clock interrupt controller (KW11-L equivalent) sitting directly downstream of the reset/power generator. Consumes its 50 Hz `irq50` square wave and its `dclo`/`aclo` power signals, exposes the single KW11-L control/status register (LCS, 177546) on the Wishbone bus, and raises a vectored interrupt (vector 100 octal) to the CPU interrupt arbiter on every tick while enabled.

## Interface
Parameters:
- `VECTOR`, default 8'o100: interrupt vector presented on `ivec`.

Ports (clock and reset first):
- `clk`  in  1  system clock, 50 MHz.
- `rstin`  in  1  asynchronous active-low reset; 0 = reset, 1 = run.
- `dclo`  in  1  DC power fail; 1 = synchronous clear of all state, same effect as reset.
- `aclo`  in  1  AC power fail; 1 = ticks ignored, no new interrupts.
- `irq50`  in  1  50 Hz square wave; each rising edge is one tick.
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i`  in  1  Wishbone cycle, strobe and write.
- `wb_sel_i`  in  2  byte selects; only `[0]` is significant.
- `wb_dat_i`  in  16  write data.
- `wb_dat_o`  out  16  read data.
- `wb_ack_o`  out  1  Wishbone acknowledge.
- `irq`  out  1  interrupt request.
- `iack`  in  1  interrupt acknowledge from arbiter.
- `ivec`  out  9  vector; always `{1'b0, VECTOR}`.

## Operation
- LCS register: bit 7 LCM (monitor), bit 6 IE (interrupt enable); all other bits read 0.
- Tick: rising edge of `irq50` while `aclo`=0 sets LCM. If IE=1, it also sets the internal pending flag.
- Write (cyc & stb & we & sel[0]): IE <= dat[6]. Writing dat[7]=0 clears LCM; writing 1 leaves LCM unchanged. With sel[0]=0 the write has no effect.
- Read: `wb_dat_o` = {8'b0, LCM, IE, 6'b0}, valid while `wb_ack_o`=1.
- Interrupt FSM:
  - IDLE: `irq`=0. pending & IE -> REQ.
  - REQ: `irq`=1. `iack`=1 -> ACK, pending cleared. IE cleared -> IDLE, pending cleared.
  - ACK: `irq`=0. Waits for `iack`=0 -> IDLE.
- A tick while pending is already set is merged; there is no overrun count.
- Tick in the same cycle as a write clearing LCM: tick wins, LCM=1.
- Tick in the same cycle as `iack` in REQ: `iack` clears the old request and the tick sets pending again; a new `irq` is raised after ACK -> IDLE.
- `dclo`=1 or `rstin`=0 mid-request: FSM -> IDLE, `irq` drops; no acknowledge is owed.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `irq`=0, LCM=0, IE=0, FSM=IDLE, edge-detect history=0. The edge-detect history resets to 0, so `irq50`=1 at reset exit counts as a tick.
- Tick latency: `irq50` sampled high at edge n, having been low at n-1 -> LCM=1 after edge n+1. With IE=1, `irq`=1 after edge n+2.
- Ack: `wb_ack_o`=1 one cycle after cyc&stb are first seen. It stays high while stb is held and drops the cycle after stb drops. A write takes effect on the cycle that asserts ack.
- `irq` drops one cycle after `iack` is sampled high.

## Configuration
- `KW11L_SYNC_EN` defined: `irq50` passes through a 2-flop synchronizer before edge detection, adding 2 cycles to tick latency. Use when `irq50` comes from another clock domain or a pin.
- Not defined: `irq50` is used directly; it must be synchronous to `clk`.

## Structure
- Shared package: LCS address 177546, bit positions LCM=7 and IE=6, default vector 8'o100, FSM state encoding.
- One sub-module, `kw11l_tick`: optional synchronizer (under the macro) plus rising-edge detector. Output is a one-cycle `tick` pulse.

## Test plan
- Reset, then IE=0, one `irq50` rising edge -> LCM=1, read returns 16'o000200, `irq` stays 0.
- Write 16'o000100, then a tick -> `irq`=1 two cycles after the edge. Pulse `iack` -> `irq`=0 next cycle, `ivec`=9'o100.
- Write 16'o000100 (bit 7=0) -> LCM cleared, IE stays 1. Write 16'o000300 -> LCM unchanged.
- Tick in the same cycle as a write of 0 -> LCM=1. Tick in the same cycle as `iack` -> second `irq` after `iack` drops.
- `aclo`=1 with IE=1 during 3 ticks -> LCM stays 0 and `irq` stays 0. `dclo` pulse while `irq`=1 -> `irq`=0, LCS reads 0.
- With `KW11L_SYNC_EN` defined -> tick latency 2 cycles longer than the non-macro case.
